// File: rtl/evt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : evt_pkg
//  Description : Shared types and helpers for the event-window controller and
//                its event counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package evt_pkg;

    // Width of the reported count; a 65_536 modulus still fits.
    localparam int unsigned c_result_w = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        MEASURE = 2'd2,
        LATCH   = 2'd3
    } evt_win_state_t;

    // Highest value the counter reaches before wrapping back to zero.
    function automatic logic [c_result_w-1:0] last_count(input int unsigned modulus);
        return c_result_w'(modulus - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/evt_counter.sv
`default_nettype none
// ============================================================================
//  Module      : evt_counter
//  Description : Event counter that increments once per high evt_in cycle and
//                wraps to zero at MAX_COUNT.
//  Revision    : 1.0 - initial release
// ============================================================================
module evt_counter
    import evt_pkg::*;
#(
    parameter int unsigned MAX_COUNT = 40_000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  evt_in,
    output logic [c_result_w-1:0] count_out
);

    localparam logic [c_result_w-1:0] c_last = last_count(MAX_COUNT);

    logic [c_result_w-1:0] r_count;

    // Count events modulo MAX_COUNT; reset wins over an event in the same cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_count <= '0;
        end else if (evt_in) begin
            if (r_count == c_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign count_out = r_count;

endmodule
`default_nettype wire

// File: rtl/evt_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : evt_window_ctrl
//  Description : Measurement-window controller. Clears an evt_counter, gates
//                events into it for WINDOW_CYCLES cycles, then latches the
//                count and a wrap flag, optionally re-arming continuously.
//  Revision    : 1.0 - initial release
// ============================================================================
module evt_window_ctrl
    import evt_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 1_000_000,
    parameter int unsigned MAX_COUNT     = 40_000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  evt_in,
    input  logic                  start_in,
    input  logic                  continuous_in,
    input  logic                  abort_in,
    output logic                  busy_out,
    output logic [c_result_w-1:0] result_out,
    output logic                  overflow_out,
    output logic                  result_valid_out
);

    localparam int unsigned               c_win_w    = $clog2(WINDOW_CYCLES + 1);
    localparam logic [c_win_w-1:0]        c_win_last = c_win_w'(WINDOW_CYCLES - 1);
    localparam logic [c_result_w-1:0]     c_cnt_last = last_count(MAX_COUNT);

    evt_win_state_t        r_state;
    logic                  r_busy;
    logic [c_result_w-1:0] r_result;
    logic                  r_overflow;
    logic                  r_valid;
    logic [c_win_w-1:0]    r_win_cnt;
    logic                  r_sticky;

    logic                  w_cnt_rst;
    logic                  w_cnt_evt;
    logic                  w_wrap;
    logic [c_result_w-1:0] w_count;

    // Counter is held in reset during CLEAR and only sees events during MEASURE.
    assign w_cnt_rst = rst_in | (r_state == CLEAR);
    assign w_cnt_evt = evt_in & (r_state == MEASURE);
    assign w_wrap    = w_cnt_evt & (w_count == c_cnt_last);

    evt_counter #(
        .MAX_COUNT (MAX_COUNT)
    ) u_counter (
        .clk_in    (clk_in),
        .rst_in    (w_cnt_rst),
        .evt_in    (w_cnt_evt),
        .count_out (w_count)
    );

    // Window sequencer with registered busy, result and valid outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_win_cnt  <= '0;
            r_sticky   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (abort_in && (r_state != IDLE)) begin
                // Drop the window entirely; previous result stays visible.
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        // A start paired with an abort is treated as cancelled.
                        if (start_in && !abort_in) begin
                            r_state <= CLEAR;
                            r_busy  <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        r_win_cnt <= '0;
                        r_sticky  <= 1'b0;
                        r_state   <= MEASURE;
                        r_busy    <= 1'b1;
                    end
                    MEASURE: begin
                        r_win_cnt <= r_win_cnt + 1'b1;
                        if (w_wrap) begin
                            r_sticky <= 1'b1;
                        end
                        if (r_win_cnt == c_win_last) begin
                            r_state <= LATCH;
                        end
                    end
                    LATCH: begin
                        // The last MEASURE event is already in w_count here.
                        r_result   <= w_count;
                        r_overflow <= r_sticky | w_wrap;
                        r_valid    <= 1'b1;
                        if (continuous_in) begin
                            r_state <= CLEAR;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy_out         = r_busy;
    assign result_out       = r_result;
    assign overflow_out     = r_overflow;
    assign result_valid_out = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_evt_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_evt_window_ctrl
//  Description : Directed scoreboard bench for evt_window_ctrl with a
//                10-cycle window and a modulus of 8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_evt_window_ctrl;

    localparam int unsigned WIN = 10;
    localparam int unsigned MAXC = 8;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        evt_in = 1'b0;
    logic        start_in = 1'b0;
    logic        continuous_in = 1'b0;
    logic        abort_in = 1'b0;
    logic        busy_out;
    logic [15:0] result_out;
    logic        overflow_out;
    logic        result_valid_out;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  e;
    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;

    // Expectations handed from the driver to the checker for the current cycle.
    logic        chk_busy_en = 1'b0;
    logic        exp_busy = 1'b0;
    logic        chk_hold_en = 1'b0;
    logic [15:0] exp_res = '0;
    logic        exp_ovf = 1'b0;
    logic        chk_empty_en = 1'b0;
    string       chk_name = "";

    evt_window_ctrl #(
        .WINDOW_CYCLES (WIN),
        .MAX_COUNT     (MAXC)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .evt_in           (evt_in),
        .start_in         (start_in),
        .continuous_in    (continuous_in),
        .abort_in         (abort_in),
        .busy_out         (busy_out),
        .result_out       (result_out),
        .overflow_out     (overflow_out),
        .result_valid_out (result_valid_out)
    );

    always #5 clk_in = ~clk_in;

    // Cycle index: value seen between one rising edge and the next.
    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor / checker: sole owner of the comparison counters.
    always @(negedge clk_in) begin
        if (result_valid_out) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: cycle %0d result %0d overflow %0b, no result required",
                         cyc, result_out, overflow_out);
            end else begin
                e = sb_q.pop_front();
                if (result_out !== e.res || overflow_out !== e.ovf || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL result: got %0d/%0b at cycle %0d, required %0d/%0b at cycle %0d",
                             result_out, overflow_out, cyc, e.res, e.ovf, e.cyc);
                end
            end
        end
        if (chk_busy_en) begin
            n_vec++;
            if (busy_out !== exp_busy) begin
                n_err++;
                $display("FAIL busy_%s: cycle %0d got %0b required %0b", chk_name, cyc, busy_out, exp_busy);
            end
        end
        if (chk_hold_en) begin
            n_vec++;
            if (result_out !== exp_res || overflow_out !== exp_ovf || result_valid_out !== 1'b0) begin
                n_err++;
                $display("FAIL hold_%s: cycle %0d got %0d/%0b valid %0b required %0d/%0b valid 0",
                         chk_name, cyc, result_out, overflow_out, result_valid_out, exp_res, exp_ovf);
            end
        end
        if (chk_empty_en) begin
            n_vec++;
            if (sb_q.size() != 0) begin
                n_err++;
                $display("FAIL missing_valid: %0d results never delivered, required 0", sb_q.size());
            end
        end
    end

    // Advance to just after the next rising edge and clear per-cycle checks.
    task automatic tick();
        @(posedge clk_in);
        #1;
        chk_busy_en  = 1'b0;
        chk_hold_en  = 1'b0;
        chk_empty_en = 1'b0;
    endtask

    task automatic push(input logic [15:0] r, input logic o, input int c);
        exp_t x;
        x.res = r;
        x.ovf = o;
        x.cyc = c;
        sb_q.push_back(x);
    endtask

    // Basic window: 5 events on alternate MEASURE cycles, a stray start while busy.
    task automatic basic_window(input string nm);
        int base;
        base = cyc;
        for (int i = 0; i < 16; i++) begin
            start_in    = (i == 0) || (i == 5);
            evt_in      = (i >= 2) && (i <= 10) && (i % 2 == 0);
            chk_name    = nm;
            chk_busy_en = 1'b1;
            exp_busy    = (i >= 1) && (i <= 12);
            if (i == 0) push(16'd5, 1'b0, base + 13);
            tick();
        end
        start_in = 1'b0;
        evt_in   = 1'b0;
    endtask

    initial begin
        int base;

        // Reset and check reset values.
        repeat (3) tick();
        rst_in = 1'b0;
        chk_name    = "reset";
        chk_busy_en = 1'b1;
        exp_busy    = 1'b0;
        chk_hold_en = 1'b1;
        exp_res     = 16'd0;
        exp_ovf     = 1'b0;
        tick();

        basic_window("basic");

        // Wrap: events every cycle; only the 10 MEASURE cycles count.
        base = cyc;
        for (int i = 0; i < 16; i++) begin
            start_in = (i == 0);
            evt_in   = 1'b1;
            if (i == 0) push(16'd2, 1'b1, base + 13);
            tick();
        end
        base = cyc;
        for (int i = 0; i < 16; i++) begin
            start_in = (i == 0);
            evt_in   = (i == 3) || (i == 5) || (i == 7);
            if (i == 0) push(16'd3, 1'b0, base + 13);
            tick();
        end

        // Gating: events only in IDLE, CLEAR and LATCH.
        base = cyc;
        for (int i = 0; i < 16; i++) begin
            start_in    = (i == 0);
            evt_in      = (i <= 1) || (i >= 12);
            chk_name    = "gating";
            chk_busy_en = 1'b1;
            exp_busy    = (i >= 1) && (i <= 12);
            if (i == 0) push(16'd0, 1'b0, base + 13);
            tick();
        end

        // Continuous: three windows, continuous dropped at cycle 30.
        base = cyc;
        for (int i = 0; i < 46; i++) begin
            start_in      = (i == 0) || (i == 20);
            continuous_in = (i < 30);
            evt_in        = (i == 2) || ((i >= 14) && (i <= 25)) || (i == 35) || (i == 36);
            chk_name      = "continuous";
            chk_busy_en   = 1'b1;
            exp_busy      = (i >= 1) && (i <= 36);
            if (i == 0) begin
                push(16'd1, 1'b0, base + 13);
                push(16'd2, 1'b1, base + 25);
                push(16'd1, 1'b0, base + 37);
            end
            tick();
        end
        continuous_in = 1'b0;

        // Abort at cycle 6, then start+abort together in IDLE.
        for (int i = 0; i < 21; i++) begin
            start_in    = (i == 0) || (i == 8);
            abort_in    = (i == 6) || (i == 8);
            evt_in      = (i == 2) || (i == 3);
            chk_name    = "abort";
            chk_busy_en = 1'b1;
            exp_busy    = (i >= 1) && (i <= 6);
            chk_hold_en = (i == 7) || (i == 20);
            exp_res     = 16'd1;
            exp_ovf     = 1'b0;
            tick();
        end
        start_in = 1'b0;
        abort_in = 1'b0;
        evt_in   = 1'b0;

        // Reset mid-MEASURE after a prior result of 5.
        basic_window("prereset");
        for (int i = 0; i < 8; i++) begin
            start_in    = (i == 0);
            evt_in      = (i == 2) || (i == 4);
            rst_in      = (i == 5);
            chk_name    = "midreset";
            chk_busy_en = 1'b1;
            exp_busy    = (i >= 1) && (i <= 5);
            chk_hold_en = (i == 6);
            exp_res     = 16'd0;
            exp_ovf     = 1'b0;
            tick();
        end
        rst_in   = 1'b0;
        start_in = 1'b0;
        evt_in   = 1'b0;
        basic_window("postreset");

        repeat (4) tick();
        chk_empty_en = 1'b1;
        @(negedge clk_in);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/evt_window_ctrl.md
# evt_window_ctrl

Measurement-window controller for the event counter. It sequences an `evt_counter` instance through clear, a gated counting window of fixed length, and result capture. It delivers one latched count per window, with an overflow flag, to downstream logic such as a rate or frequency display. It sits between raw single-cycle event pulses and any consumer that needs events-per-window rather than a free-running count.

## Interface
- WINDOW_CYCLES, 1_000_000: gate length in clk_in cycles; must be ≥ 1.
- MAX_COUNT, 40_000: wrap modulus of the internal counter; must be ≤ 65_536.
- clk_in  in  1  system clock.
- rst_in  in  1  reset; synchronous, active-high.
- evt_in  in  1  event pulse, already synchronous to clk_in; one event per high cycle.
- start_in  in  1  request a measurement; honoured only in IDLE.
- continuous_in  in  1  re-arm automatically after each window; sampled in LATCH.
- abort_in  in  1  cancel the current window; no result is produced.
- busy_out  out  1  high in any state other than IDLE.
- result_out  out  16  events counted in the last completed window, modulo MAX_COUNT.
- overflow_out  out  1  the last completed window wrapped the counter at least once.
- result_valid_out  out  1  one-cycle pulse when result_out and overflow_out update.

## Operation
- States:
  - IDLE: waiting for a request.
  - CLEAR: one cycle; asserts the counter reset.
  - MEASURE: exactly WINDOW_CYCLES cycles; evt_in is gated through to the counter.
  - LATCH: one cycle; captures the count.
- Transitions:
  - IDLE → CLEAR on start_in.
  - CLEAR → MEASURE.
  - MEASURE → LATCH when the window counter equals WINDOW_CYCLES-1.
  - LATCH → CLEAR if continuous_in=1, otherwise LATCH → IDLE.
- Window counter:
  - Width is $clog2(WINDOW_CYCLES+1).
  - Zeroed in CLEAR; increments every MEASURE cycle.
- Counter drive:
  - Counter reset = rst_in OR (state==CLEAR).
  - Counter event = evt_in AND (state==MEASURE).
  - Events in IDLE, CLEAR and LATCH are dropped, giving 2 dead cycles per window in continuous mode.
- Overflow:
  - Sticky flag, cleared in CLEAR.
  - Set in MEASURE when the gated event is high and the counter equals MAX_COUNT-1.
- Capture on the edge leaving LATCH:
  - result_out ← counter value.
  - overflow_out ← sticky flag, OR'd with the same wrap condition for the final MEASURE cycle.
  - result_valid_out ← 1.
- result_out and overflow_out hold their values until the next capture.
- Priority:
  - rst_in takes precedence over abort_in, and abort_in over everything else.
  - abort_in in any non-IDLE state → IDLE next cycle; no capture; result_out and overflow_out hold.
  - abort_in in IDLE has no effect.
  - start_in while busy is ignored; it is not queued.
  - start_in and abort_in together in IDLE → stays IDLE.

## Timing
- Reset values:
  - State = IDLE.
  - busy_out=0, result_out=0, overflow_out=0, result_valid_out=0.
  - Window counter, sticky flag and internal counter = 0.
- Reset mid-operation: IDLE on the next cycle, with all of the above reset values.
- Single-shot sequence (start_in high in cycle t, in IDLE):
  - CLEAR in t+1.
  - MEASURE in t+2 … t+1+WINDOW_CYCLES.
  - LATCH in t+2+WINDOW_CYCLES.
  - result_valid_out high in t+3+WINDOW_CYCLES only.
- busy_out is high from t+1 through t+2+WINDOW_CYCLES. It is registered from the state.
- Counter latency:
  - An event in MEASURE cycle k is visible in the count at k+1.
  - An event in the last MEASURE cycle is therefore included in the capture.
- Continuous mode: valid pulses are spaced exactly WINDOW_CYCLES+2 cycles apart.
- Stopping continuous mode: deasserting continuous_in before LATCH makes the current window the last one.

## Structure
- Package `evt_pkg`: typedef enum logic [1:0] `evt_win_state_t` {IDLE, CLEAR, MEASURE, LATCH}.
- Sub-module: one `evt_counter` instance with MAX_COUNT passed through. Its clk_in is shared; its rst_in and evt_in are driven by the gated signals above.
- All control, the window counter, the sticky flag and the output registers are local to evt_window_ctrl.

## Test plan
All scenarios use WINDOW_CYCLES=10, MAX_COUNT=8.
- Basic window:
  - Stimulus: start_in pulse at cycle 0; evt_in high on alternate MEASURE cycles (5 events).
  - Required: result_out=5, overflow_out=0; valid only at cycle 13; busy_out high on cycles 1–12.
- Wrap:
  - Stimulus: evt_in held high throughout.
  - Required: exactly 10 events counted; result_out=2, overflow_out=1.
  - A following window with 3 events gives result_out=3, overflow_out=0.
- Gating:
  - Stimulus: evt_in high only in IDLE, CLEAR and LATCH cycles.
  - Required: result_out=0, overflow_out=0.
- Continuous:
  - Stimulus: continuous_in=1 and start_in.
  - Required: valid pulses at cycles 13, 25 and 37.
  - Dropping continuous_in at cycle 30: no pulse after cycle 37; busy_out low from cycle 37.
- Abort:
  - Stimulus: abort_in at cycle 6.
  - Required: IDLE and busy_out=0 at cycle 7; no valid pulse; previous result_out held.
  - A start_in issued the same cycle as abort_in in IDLE is ignored.
- Reset mid-MEASURE:
  - Stimulus: rst_in at cycle 5 after a prior result of 5.
  - Required: result_out=0, overflow_out=0, busy_out=0 next cycle; the following full window behaves as in the basic-window scenario.
